// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// funct3 op encodings, FSM state type and special-case constants.
package mdu_pkg;

  localparam int MDU_N = 64;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [MDU_N-1:0] MDU_ALL_ONES = '1;
  localparam logic [MDU_N-1:0] MDU_MOST_NEG = {1'b1, {(MDU_N-1){1'b0}}};

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign correction and half selection of a 2N-bit magnitude result.
// Products are negated across all 2N bits; quotient/remainder only within their half.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic [2*N-1:0] mag,
  input  logic           neg,
  input  logic           sel_hi,
  input  logic           wide,
  output logic [N-1:0]   value
);

  logic [2*N-1:0] full;
  logic [N-1:0]   half;

  always_comb begin
    full  = (neg && wide) ? -mag : mag;
    half  = sel_hi ? full[2*N-1:N] : full[N-1:0];
    value = (neg && !wide) ? -half : half;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign-correction cycle.
//
// state | meaning
// IDLE  | waiting for start; operands, tag and sign flags captured on start
// CALC  | one radix-2 step per cycle, N cycles
// FIX   | sign correction and result/wr_addr load
// DONE  | done/reg_write pulse, back to IDLE
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int N           = MDU_N,
  parameter int ADDRESS_LEN = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [N-1:0]           rs1_data,
  input  logic [N-1:0]           rs2_data,
  input  logic [ADDRESS_LEN-1:0] rd_tag,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           result,
  output logic [ADDRESS_LEN-1:0] wr_addr,
  output logic                   reg_write
);

  localparam int CNT_W = $clog2(N) + 1;
  // N must not exceed MDU_N for these truncations to hold
  localparam logic [N-1:0] ALL_ONES = N'(MDU_ALL_ONES);
  localparam logic [N-1:0] MOST_NEG = N'(MDU_MOST_NEG >> (MDU_N - N));

  mdu_state_e             state, state_nxt;
  mdu_op_e                op_in, op_q;
  logic [ADDRESS_LEN-1:0] tag_q;
  logic [2*N-1:0]         acc, acc_step;
  logic [N-1:0]           opnd;
  logic                   neg_q;
  logic [CNT_W-1:0]       cnt;

  logic                   a_signed, b_signed, a_neg, b_neg;
  logic                   div_zero, div_ovf, special;
  logic [N-1:0]           a_mag, b_mag;
  logic [N:0]             mul_sum, div_shift, div_diff;
  logic                   fix_hi, fix_wide;
  logic [N-1:0]           fix_val;

  assign op_in = mdu_op_e'(op);

  always_comb begin
    a_signed = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
    b_signed = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
    a_neg    = a_signed && rs1_data[N-1];
    b_neg    = b_signed && rs2_data[N-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = op[2] && (rs2_data == '0);
    div_ovf  = op[2] && !op[0] && (rs1_data == MOST_NEG) && (rs2_data == ALL_ONES);
    special  = div_zero || div_ovf;
  end

  // acc holds {high product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*N-1:N-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (op_q[2]) begin
      acc_step = div_diff[N] ? {acc[2*N-2:0], 1'b0}
                             : {div_diff[N-1:0], acc[N-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[N-1:1]};
    end
  end

  assign fix_wide = !op_q[2];
  assign fix_hi   = op_q[2] ? op_q[1] : (op_q != MUL);

  mdu_sign_fix #(.N(N)) u_sign_fix (
    .mag    (acc),
    .neg    (neg_q),
    .sel_hi (fix_hi),
    .wide   (fix_wide),
    .value  (fix_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Special cases still pass through FIX so that result loads in one place
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    reg_write = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= MUL;
      tag_q   <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      wr_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op_in;
          tag_q <= rd_tag;
          if (special) begin
            // Preload so FIX selects quotient/remainder straight out of acc
            acc   <= div_zero ? {rs1_data, ALL_ONES} : {{N{1'b0}}, MOST_NEG};
            opnd  <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
          end else begin
            acc   <= op[2] ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, b_mag};
            opnd  <= op[2] ? b_mag : a_mag;
            neg_q <= (op_in == REM) ? a_neg : (a_neg ^ b_neg);
            cnt   <= CNT_W'(N);
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          result  <= fix_val;
          wr_addr <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV64M cases plus random
// operations checked against an arithmetic reference model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int          NB      = 64;
  localparam int          NLAT    = NB + 1;
  localparam int          TIMEOUT = 300;
  localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [63:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_tag, wr_addr;
  logic        busy, done, reg_write;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  addr;
    int          lat;
    bit          busy_hold;
    bit          res_stable;
    bit          strobe;
    bit          one_shot;
    bit          held;
  } obs_t;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  mdu_iterative #(.N(NB), .ADDRESS_LEN(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_tag    (rd_tag),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wr_addr   (wr_addr),
    .reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mdu(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[63:0];   end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ONES64;
        if (a == MIN64 && b == ONES64) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? ONES64 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES64) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN64 && b == ONES64))) return 1;
    return NLAT;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES64;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input int poke_at, input bit poke_done,
                        output obs_t o);
    logic [63:0] prev;
    @(negedge clk);
    start = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_tag = tag;
    prev = result;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    rd_tag = 5'($urandom);
    o.lat = 0; o.busy_hold = 1'b1; o.res_stable = 1'b1;
    while (done !== 1'b1 && o.lat < TIMEOUT) begin
      if (busy !== 1'b1) o.busy_hold = 1'b0;
      if (result !== prev) o.res_stable = 1'b0;
      start = (o.lat == poke_at);
      if (start) begin
        op = 3'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      o.lat++;
    end
    start = 1'b0;
    o.res    = result;
    o.addr   = wr_addr;
    o.strobe = (reg_write === 1'b1) && (busy === 1'b1);
    if (poke_done) begin
      start = 1'b1; op = 3'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = 64'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    o.one_shot = (done === 1'b0) && (reg_write === 1'b0) && (busy === 1'b0);
    o.held     = (result === o.res) && (wr_addr === o.addr);
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, reg_write, result, wr_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b rw=%b result=%h addr=%0d, expected all zero",
               busy, done, reg_write, result, wr_addr);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, reg_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rw=%b, expected 000", busy, done, reg_write);
    end
  endtask

  task automatic test_mul;
    obs_t o;
    run_op(3'(MUL), 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, -1, 1'b0, o);
    n_checks++;
    if (o.res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_fail++; $display("FAIL mul_result: got %h expected %h", o.res, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    n_checks++;
    if (o.lat != NLAT) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected %0d", o.lat, NLAT);
    end
    n_checks++;
    if (o.addr !== 5'd5) begin
      n_fail++; $display("FAIL mul_wr_addr: got %0d expected 5", o.addr);
    end
    n_checks++;
    if ({o.busy_hold, o.res_stable, o.strobe, o.one_shot, o.held} !== 5'b11111) begin
      n_fail++;
      $display("FAIL mul_handshake: busy_hold=%b stable=%b strobe=%b one_shot=%b held=%b, expected all 1",
               o.busy_hold, o.res_stable, o.strobe, o.one_shot, o.held);
    end
  endtask

  task automatic test_arith;
    vec_t tbl [7] = '{
      '{3'(MULHU),  ONES64, ONES64, 64'hFFFF_FFFF_FFFF_FFFE},
      '{3'(MULH),   ONES64, ONES64, 64'd0},
      '{3'(MULHSU), ONES64, 64'd2,  ONES64},
      '{3'(DIV),    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD},
      '{3'(REM),    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES64},
      '{3'(DIVU),   64'd100, 64'd7, 64'd14},
      '{3'(REMU),   64'd100, 64'd7, 64'd2}
    };
    obs_t o;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, 5'(i + 1), -1, 1'b0, o);
      n_checks++;
      if (o.res !== tbl[i].exp || o.lat != NLAT || o.addr !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL arith_op%0d: got result=%h lat=%0d addr=%0d expected result=%h lat=%0d addr=%0d",
                 tbl[i].f, o.res, o.lat, o.addr, tbl[i].exp, NLAT, i + 1);
      end
    end
  endtask

  task automatic test_special;
    vec_t tbl [4] = '{
      '{3'(DIV), 64'd42, 64'd0,  ONES64},
      '{3'(REM), 64'd42, 64'd0,  64'd42},
      '{3'(DIV), MIN64,  ONES64, MIN64},
      '{3'(REM), MIN64,  ONES64, 64'd0}
    };
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, 5'(20 + i), -1, 1'b0, o);
      n_checks++;
      if (o.res !== tbl[i].exp || o.lat != 1 || !o.strobe || !o.one_shot || o.addr !== 5'(20 + i)) begin
        n_fail++;
        $display("FAIL special_%0d: got result=%h lat=%0d strobe=%b one_shot=%b addr=%0d expected result=%h lat=1",
                 i, o.res, o.lat, o.strobe, o.one_shot, o.addr, tbl[i].exp);
      end
    end
  endtask

  task automatic test_ignore_start;
    obs_t o;
    run_op(3'(DIVU), 64'd1000, 64'd3, 5'd9, 5, 1'b1, o);
    n_checks++;
    if (o.res !== 64'd333 || o.lat != NLAT || o.addr !== 5'd9) begin
      n_fail++;
      $display("FAIL ignore_start_result: got result=%h lat=%0d addr=%0d expected result=%h lat=%0d addr=9",
               o.res, o.lat, o.addr, 64'd333, NLAT);
    end
    n_checks++;
    if (!o.one_shot || !o.busy_hold) begin
      n_fail++;
      $display("FAIL ignore_start_idle: got one_shot=%b busy_hold=%b expected 1 1", o.one_shot, o.busy_hold);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2;
    run_op(3'(MUL),  64'd123456, 64'd1000, 5'd11, -1, 1'b0, o1);
    run_op(3'(REMU), 64'd1000,   64'd7,    5'd12, -1, 1'b0, o2);
    n_checks++;
    if (o1.res !== 64'd123456000 || o2.res !== 64'd6) begin
      n_fail++;
      $display("FAIL b2b_results: got %h %h expected %h %h", o1.res, o2.res, 64'd123456000, 64'd6);
    end
    n_checks++;
    if (o2.lat != NLAT || o2.addr !== 5'd12 || !o2.res_stable) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d addr=%0d stable=%b expected lat=%0d addr=12 stable=1",
               o2.lat, o2.addr, o2.res_stable, NLAT);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    logic busy_before;
    @(negedge clk);
    start = 1'b1; op = 3'(DIVU); rs1_data = 64'd12345; rs2_data = 64'd7; rd_tag = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    busy_before = busy;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy_before !== 1'b1 || {busy, done, reg_write, result, wr_addr} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: busy_before=%b got busy=%b done=%b rw=%b result=%h addr=%0d expected busy_before=1 rest 0",
               busy_before, busy, done, reg_write, result, wr_addr);
    end
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (2 * NB + 10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || reg_write !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_random;
    obs_t        o;
    logic [2:0]  f;
    logic [63:0] a, b, exp;
    logic [4:0]  tag;
    int          exp_lat;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      tag = 5'($urandom);
      exp = ref_mdu(f, a, b);
      exp_lat = ref_lat(f, a, b);
      run_op(f, a, b, tag, -1, 1'b0, o);
      n_checks++;
      if (o.res !== exp || o.lat != exp_lat || o.addr !== tag || !o.strobe || !o.one_shot) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got result=%h lat=%0d addr=%0d expected result=%h lat=%0d addr=%0d",
                 i, f, a, b, o.res, o.lat, o.addr, exp, exp_lat, tag);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_tag = '0;
    test_reset();
    test_mul();
    test_arith();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
